keypad_scan_db: RTL and testbench

KEYPAD_SCAN_DB -- requirements
Module: keypad_scan_db

---
 rtl/keypad_pkg.sv | 16 +
 rtl/sync2.sv | 28 ++
 rtl/keypad_scan_db.sv | 185 ++++++++++++++++++
 tb/tb_keypad_scan_db.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN       = 2'd0,
    ST_PRESS_DB   = 2'd1,
    ST_HELD       = 2'd2,
    ST_RELEASE_DB = 2'd3
  } kp_state_e;

  // Bits needed to index n items; never narrower than one bit.
  function automatic int code_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous inputs; resets to all-ones
// so idle (active-low) lines read as inactive out of reset.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // Two-stage capture of the raw input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan_db.sv
// Row-scanning keypad controller with press/release debounce and a
// single-entry event register.
//
// state         | meaning
// --------------+-------------------------------------------------
// ST_SCAN       | rotate the low row, look for any low column
// ST_PRESS_DB   | row frozen, count stable-low cycles of the key
// ST_HELD       | key accepted and reported, waiting for release
// ST_RELEASE_DB | count stable-high cycles before resuming scan
module keypad_scan_db
  import keypad_pkg::*;
#(
  parameter int NROWS     = 4,
  parameter int NCOLS     = 4,
  parameter int SCAN_DIV  = 4,
  parameter int DB_CYCLES = 20000
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NCOLS-1:0]                 cols_n,
  output logic [NROWS-1:0]                 rows_n,
  output logic                             key_valid,
  input  logic                             key_ready,
  output logic [code_w(NROWS*NCOLS)-1:0]   key_code,
  output logic                             key_down,
  output logic                             overflow
);

  localparam int CW   = code_w(NROWS*NCOLS);
  localparam int RW   = code_w(NROWS);
  localparam int CLW  = code_w(NCOLS);
  localparam int DW   = code_w(SCAN_DIV);
  localparam int CNTW = code_w(DB_CYCLES+1);

  logic [NCOLS-1:0] cols_s;
  kp_state_e        state_q;
  logic [RW-1:0]    row_q;
  // Row that was driven when the currently synchronized column sample was
  // taken; the sync delay means rows_n has already moved on by then.
  logic [RW-1:0]    row_s1_q, row_s2_q;
  logic [DW-1:0]    div_q;
  logic [CNTW-1:0]  cnt_q;
  logic [CLW-1:0]   cap_col_q;
  logic             down_q;
  logic             valid_q;
  logic [CW-1:0]    code_q;
  logic             ovf_q;

  logic             any_low, aligned, cap_low, db_done, emit, accept;
  logic [CLW-1:0]   low_col;
  logic [CNTW-1:0]  cnt_inc;
  logic [CW-1:0]    new_code;

  function automatic logic [RW-1:0] next_row(input logic [RW-1:0] r);
    if (r == RW'(NROWS-1)) return '0;
    return r + 1'b1;
  endfunction

  sync2 #(.W(NCOLS)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (cols_n),
    .q_o   (cols_s)
  );

  // Column decode, saturating count and event strobe.
  always_comb begin
    any_low = ~&cols_s;
    low_col = '0;
    for (int i = NCOLS-1; i >= 0; i--) begin
      if (!cols_s[i]) low_col = CLW'(i);
    end
    aligned  = (row_s2_q == row_q);
    cap_low  = !cols_s[cap_col_q];
    cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    db_done  = (cnt_inc == CNTW'(DB_CYCLES));
    emit     = (state_q == ST_PRESS_DB) && aligned && cap_low && db_done;
    new_code = CW'(int'(row_q) * NCOLS + int'(cap_col_q));
    accept   = valid_q && key_ready;
  end

  // Scan/debounce state machine; samples are only trusted once the
  // frozen row has propagated through the synchronizer (aligned).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_SCAN;
      row_q     <= '0;
      row_s1_q  <= '0;
      row_s2_q  <= '0;
      div_q     <= '0;
      cnt_q     <= '0;
      cap_col_q <= '0;
      down_q    <= 1'b0;
    end else begin
      row_s1_q <= row_q;
      row_s2_q <= row_s1_q;
      case (state_q)
        ST_SCAN: begin
          if (any_low) begin
            state_q   <= ST_PRESS_DB;
            row_q     <= row_s2_q;
            cap_col_q <= low_col;
            cnt_q     <= '0;
            div_q     <= '0;
          end else if (div_q == DW'(SCAN_DIV-1)) begin
            div_q <= '0;
            row_q <= next_row(row_q);
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        ST_PRESS_DB: begin
          if (aligned) begin
            if (!cap_low) begin
              state_q <= ST_SCAN;
              row_q   <= next_row(row_q);
              cnt_q   <= '0;
            end else if (db_done) begin
              state_q <= ST_HELD;
              down_q  <= 1'b1;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end
        ST_HELD: begin
          if (aligned && !cap_low) begin
            state_q <= ST_RELEASE_DB;
            cnt_q   <= '0;
          end
        end
        ST_RELEASE_DB: begin
          if (aligned) begin
            if (cap_low) begin
              state_q <= ST_HELD;
              cnt_q   <= '0;
            end else if (db_done) begin
              state_q <= ST_SCAN;
              down_q  <= 1'b0;
              row_q   <= next_row(row_q);
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end
        default: state_q <= ST_SCAN;
      endcase
    end
  end

  // Single-entry event holding register with drop-on-full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      code_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      ovf_q <= 1'b0;
      if (emit) begin
        if (!valid_q || accept) begin
          code_q  <= new_code;
          valid_q <= 1'b1;
        end else begin
          ovf_q <= 1'b1;
        end
      end else if (accept) begin
        valid_q <= 1'b0;
      end
    end
  end

  // One-cold row drive from the current row index.
  always_comb begin
    rows_n        = '1;
    rows_n[row_q] = 1'b0;
  end

  assign key_valid = valid_q;
  assign key_code  = code_q;
  assign key_down  = down_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_keypad_scan_db.sv
// Bench for keypad_scan_db: a physical keypad model closes row/column
// contacts, a monitor logs accepted events and overflow pulses.
module tb_keypad_scan_db;

  localparam int NR = 4;
  localparam int NC = 4;
  localparam int SD = 2;
  localparam int DB = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [NC-1:0] cols_n;
  logic [NR-1:0] rows_n;
  logic          key_valid, key_ready, key_down, overflow;
  logic [3:0]    key_code;
  logic [NR*NC-1:0] key_mask;

  int checks = 0;
  int errors = 0;
  int ovf_cnt = 0;
  int obs_q[$];

  always #5 clk = ~clk;

  keypad_scan_db #(
    .NROWS(NR), .NCOLS(NC), .SCAN_DIV(SD), .DB_CYCLES(DB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cols_n    (cols_n),
    .rows_n    (rows_n),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_code  (key_code),
    .key_down  (key_down),
    .overflow  (overflow)
  );

  // Keypad: a pressed key shorts its column low while its row is driven low.
  always_comb begin
    cols_n = '1;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        if (key_mask[r*NC+c] && !rows_n[r]) cols_n[c] = 1'b0;
  end

  // Log handshakes and overflow pulses away from the clock edge.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (key_valid && key_ready) obs_q.push_back(int'(key_code));
      if (overflow) ovf_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    key_mask = '0;
    key_ready = 1'b0;
    tick(3);
    reset = 1'b0;
    obs_q.delete();
    ovf_cnt = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    key_mask = '0;
    key_ready = 1'b0;
    tick(2);
    checks++;
    if (rows_n !== 4'b1110) begin errors++; $display("FAIL reset_rows: got %b expected 1110", rows_n); end
    checks++;
    if ({key_valid, key_down, overflow} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got v/d/o=%b expected 000", {key_valid, key_down, overflow});
    end
    checks++;
    if (key_code !== 4'd0) begin errors++; $display("FAIL reset_code: got %0d expected 0", key_code); end
    tick(1);
    reset = 1'b0;
    obs_q.delete();
    ovf_cnt = 0;
  endtask

  task automatic test_scan_idle();
    logic [NR-1:0] exp_rows;
    do_reset();
    for (int n = 0; n < 24; n++) begin
      @(negedge clk);
      exp_rows = ~(4'b0001 << ((n / SD) % NR));
      checks++;
      if (rows_n !== exp_rows) begin
        errors++; $display("FAIL scan_rows[%0d]: got %b expected %b", n, rows_n, exp_rows);
      end
      checks++;
      if (key_valid !== 1'b0) begin errors++; $display("FAIL scan_valid[%0d]: got %b expected 0", n, key_valid); end
    end
    tick(1);
  endtask

  task automatic press_release(input int r, input int c, input int hold, input logic rdy);
    key_ready = rdy;
    key_mask[r*NC+c] = 1'b1;
    tick(hold);
    checks++;
    if (key_down !== 1'b1) begin errors++; $display("FAIL held_down(%0d,%0d): got %b expected 1", r, c, key_down); end
    key_mask = '0;
    tick(7);
    checks++;
    if (key_down !== 1'b1) begin errors++; $display("FAIL release_early(%0d,%0d): got %b expected 1", r, c, key_down); end
    tick(9);
    checks++;
    if (key_down !== 1'b0) begin errors++; $display("FAIL release_done(%0d,%0d): got %b expected 0", r, c, key_down); end
  endtask

  task automatic test_basic();
    obs_q.delete();
    ovf_cnt = 0;
    press_release(2, 1, 30, 1'b1);
    tick(2);
    checks++;
    if (obs_q.size() != 1) begin errors++; $display("FAIL basic_count: got %0d expected 1", obs_q.size()); end
    else if (obs_q[0] != 9) begin errors++; $display("FAIL basic_code: got %0d expected 9", obs_q[0]); end
    checks++;
    if (key_valid !== 1'b0 || ovf_cnt != 0) begin
      errors++; $display("FAIL basic_after: got valid=%b ovf=%0d expected 0/0", key_valid, ovf_cnt);
    end
  endtask

  task automatic test_random_keys();
    for (int k = 0; k < 6; k++) begin
      int r, c, exp_code;
      r = int'($urandom_range(0, NR-1));
      c = int'($urandom_range(0, NC-1));
      exp_code = r * NC + c;
      obs_q.delete();
      press_release(r, c, int'($urandom_range(30, 40)), 1'b1);
      tick(int'($urandom_range(2, 9)));
      checks++;
      if (obs_q.size() != 1) begin errors++; $display("FAIL rand_count[%0d]: got %0d expected 1", k, obs_q.size()); end
      else if (obs_q[0] != exp_code) begin errors++; $display("FAIL rand_code[%0d]: got %0d expected %0d", k, obs_q[0], exp_code); end
    end
    checks++;
    if (ovf_cnt != 0) begin errors++; $display("FAIL rand_ovf: got %0d expected 0", ovf_cnt); end
  endtask

  task automatic test_bounce();
    int r, c;
    r = int'($urandom_range(0, NR-1));
    c = int'($urandom_range(0, NC-1));
    obs_q.delete();
    key_ready = 1'b1;
    key_mask[r*NC+c] = 1'b1;
    tick(5);
    key_mask = '0;
    tick(3);
    key_mask[r*NC+c] = 1'b1;
    tick(DB);
    checks++;
    if (obs_q.size() != 0 || key_valid !== 1'b0) begin
      errors++; $display("FAIL bounce_early: got events=%0d valid=%b expected 0/0", obs_q.size(), key_valid);
    end
    tick(25);
    key_mask = '0;
    tick(20);
    checks++;
    if (obs_q.size() != 1) begin errors++; $display("FAIL bounce_count: got %0d expected 1", obs_q.size()); end
    else if (obs_q[0] != r*NC+c) begin errors++; $display("FAIL bounce_code: got %0d expected %0d", obs_q[0], r*NC+c); end
  endtask

  task automatic test_overflow();
    obs_q.delete();
    ovf_cnt = 0;
    press_release(2, 1, 30, 1'b0);
    press_release(0, 3, 30, 1'b0);
    checks++;
    if (key_valid !== 1'b1 || key_code !== 4'd9) begin
      errors++; $display("FAIL ovf_hold: got valid=%b code=%0d expected 1/9", key_valid, key_code);
    end
    checks++;
    if (ovf_cnt != 1) begin errors++; $display("FAIL ovf_pulses: got %0d expected 1", ovf_cnt); end
    key_ready = 1'b1;
    tick(1);
    key_ready = 1'b0;
    tick(1);
    checks++;
    if (obs_q.size() != 1) begin errors++; $display("FAIL ovf_accept_count: got %0d expected 1", obs_q.size()); end
    else if (obs_q[0] != 9) begin errors++; $display("FAIL ovf_accept_code: got %0d expected 9", obs_q[0]); end
    checks++;
    if (key_valid !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", key_valid); end
  endtask

  task automatic test_multi_key();
    for (int k = 0; k < 4; k++) begin
      int r, c1, c2, exp_code;
      if (k == 0) begin
        r = 1; c1 = 0; c2 = 2;
      end else begin
        r  = int'($urandom_range(0, NR-1));
        c1 = int'($urandom_range(0, NC-1));
        c2 = (c1 + int'($urandom_range(1, NC-1))) % NC;
      end
      exp_code = r * NC + ((c1 < c2) ? c1 : c2);
      obs_q.delete();
      key_ready = 1'b1;
      key_mask[r*NC+c1] = 1'b1;
      key_mask[r*NC+c2] = 1'b1;
      tick(30);
      key_mask = '0;
      tick(20);
      checks++;
      if (obs_q.size() != 1) begin errors++; $display("FAIL multi_count[%0d]: got %0d expected 1", k, obs_q.size()); end
      else if (obs_q[0] != exp_code) begin errors++; $display("FAIL multi_code[%0d]: got %0d expected %0d", k, obs_q[0], exp_code); end
    end
  endtask

  task automatic test_reset_held();
    obs_q.delete();
    key_ready = 1'b0;
    key_mask[3*NC+2] = 1'b1;
    tick(30);
    checks++;
    if (key_down !== 1'b1 || key_valid !== 1'b1 || key_code !== 4'd14) begin
      errors++; $display("FAIL rh_pre: got down=%b valid=%b code=%0d expected 1/1/14", key_down, key_valid, key_code);
    end
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    checks++;
    if ({key_valid, key_down, overflow} !== 3'b000 || key_code !== 4'd0) begin
      errors++; $display("FAIL rh_async: got v/d/o=%b code=%0d expected 000/0", {key_valid, key_down, overflow}, key_code);
    end
    checks++;
    if (rows_n !== 4'b1110) begin errors++; $display("FAIL rh_rows: got %b expected 1110", rows_n); end
    key_mask = '0;
    tick(2);
    reset = 1'b0;
    obs_q.delete();
    key_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      logic [NR-1:0] exp_rows;
      @(negedge clk);
      exp_rows = ~(4'b0001 << ((n / SD) % NR));
      checks++;
      if (rows_n !== exp_rows) begin errors++; $display("FAIL rh_scan[%0d]: got %b expected %b", n, rows_n, exp_rows); end
    end
    tick(20);
    checks++;
    if (obs_q.size() != 0 || key_valid !== 1'b0) begin
      errors++; $display("FAIL rh_discard: got events=%0d valid=%b expected 0/0", obs_q.size(), key_valid);
    end
  endtask

  initial begin
    reset = 1'b1;
    key_mask = '0;
    key_ready = 1'b0;
    test_reset();
    test_scan_idle();
    test_basic();
    test_random_keys();
    test_bounce();
    test_overflow();
    test_multi_key();
    test_reset_held();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
